// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the programmable serial sequence detector.
//   LEN_W(pat_w) : width of a pattern-length field able to hold 0..pat_w
//   OVL_ON/OFF   : overlap mode encodings
//   SEQ_0101     : default 8-bit alternating sync pattern
package seq_detect_pkg;

  function automatic int unsigned LEN_W(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  localparam logic [7:0] SEQ_0101 = 8'b0101_0101;

endpackage

// File: rtl/seq_detect_cmp.sv
// Length-limited, masked equality of the next history word against the pattern.
//   hist_n  : history including the bit being sampled (newest bit at LSB)
//   pat     : right-aligned pattern
//   mask    : 1 = compare this bit, 0 = don't-care
//   pat_len : number of low bits taking part in the compare
//   eq_c    : combinational equality result
module seq_detect_cmp
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = 8
) (
  input  logic [PAT_W-1:0]        hist_n,
  input  logic [PAT_W-1:0]        pat,
  input  logic [PAT_W-1:0]        mask,
  input  logic [LEN_W(PAT_W)-1:0] pat_len,
  output logic                    eq_c
);

  localparam int unsigned LW = LEN_W(PAT_W);

  // Any in-range, unmasked bit that differs breaks the match.
  always_comb begin
    eq_c = 1'b1;
    for (int i = 0; i < PAT_W; i++) begin
      if ((LW'(i) < pat_len) && mask[i] && (hist_n[i] != pat[i])) begin
        eq_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_detect_p.sv
// Runtime-programmable serial bit-sequence detector.
// Ports:
//   clk, rst (async, active-low)
//   din, din_vld          : serial bit and its qualifier
//   pat_load              : strobe capturing pat_in / len_in / ovl_in (and mask_in)
//   pat_in, len_in, ovl_in: new pattern, length (clamped to PAT_W), overlap mode
//   cnt_clr               : synchronous clear of match_cnt
//   flag                  : registered one-cycle match pulse
//   match_cnt             : saturating match count
//   busy_fill             : combinational, fewer than pat_len bits collected
// Optional: SEQDET_MASK_EN adds mask_in (per-bit don't-care, captured on pat_load).
module seq_detect_p
  import seq_detect_pkg::*;
#(
  parameter int unsigned     PAT_W   = 8,
  parameter int unsigned     CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(SEQ_0101),
  parameter int unsigned     RST_LEN = PAT_W,
  parameter logic            RST_OVL = OVL_ON
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    din_vld,
  input  logic                    pat_load,
  input  logic [PAT_W-1:0]        pat_in,
  input  logic [LEN_W(PAT_W)-1:0] len_in,
  input  logic                    ovl_in,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_W-1:0]        mask_in,
`endif
  input  logic                    cnt_clr,
  output logic                    flag,
  output logic [CNT_W-1:0]        match_cnt,
  output logic                    busy_fill
);

  localparam int unsigned LW = LEN_W(PAT_W);
  localparam logic [LW-1:0] LEN_MAX   = LW'(PAT_W);
  localparam logic [LW-1:0] RST_LEN_C = (RST_LEN > PAT_W) ? LW'(PAT_W) : LW'(RST_LEN);

  logic [PAT_W-1:0] hist;
  logic [LW-1:0]    fill;
  logic [PAT_W-1:0] pat;
  logic [LW-1:0]    pat_len;
  logic             ovl;
  logic [PAT_W-1:0] mask;

  logic [PAT_W-1:0] hist_n;
  logic [LW-1:0]    fill_n;
  logic             eq_c;
  logic             match_c;

  // Truncating cast drops the oldest bit as the new one enters at the LSB.
  assign hist_n = PAT_W'({hist, din});
  assign fill_n = (fill == LEN_MAX) ? fill : fill + LW'(1);

  seq_detect_cmp #(
    .PAT_W (PAT_W)
  ) u_cmp (
    .hist_n  (hist_n),
    .pat     (pat),
    .mask    (mask),
    .pat_len (pat_len),
    .eq_c    (eq_c)
  );

  // A load in the same cycle discards the beat entirely.
  assign match_c = din_vld && !pat_load && (pat_len != '0) && (fill_n >= pat_len) && eq_c;

  assign busy_fill = (fill < pat_len);

  // Pattern configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat     <= RST_PAT;
      pat_len <= RST_LEN_C;
      ovl     <= RST_OVL;
    end else if (pat_load) begin
      pat     <= pat_in;
      pat_len <= (len_in > LEN_MAX) ? LEN_MAX : len_in;
      ovl     <= ovl_in;
    end
  end

`ifdef SEQDET_MASK_EN
  // Compare mask; all ones after reset means every bit is significant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '1;
    end else if (pat_load) begin
      mask <= mask_in;
    end
  end
`else
  assign mask = '1;
`endif

  // History and fill level; a non-overlapping match restarts collection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (pat_load) begin
      hist <= '0;
      fill <= '0;
    end else if (din_vld) begin
      hist <= hist_n;
      fill <= (match_c && (ovl == OVL_OFF)) ? '0 : fill_n;
    end
  end

  // Match pulse and saturating counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag      <= 1'b0;
      match_cnt <= '0;
    end else begin
      flag <= match_c;
      if (cnt_clr) begin
        match_cnt <= '0;
      end else if (match_c && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_p.sv
// Directed self-checking bench for seq_detect_p: a default 8-bit-counter
// instance and a 2-bit-counter instance driven by the same stimulus.
module tb_seq_detect_p;
  import seq_detect_pkg::*;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned LW    = LEN_W(PAT_W);

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_vld;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic [LW-1:0]    len_in;
  logic             ovl_in;
  logic             cnt_clr;
  logic             flag, flag2;
  logic [7:0]       match_cnt;
  logic [1:0]       match_cnt2;
  logic             busy_fill, busy_fill2;
`ifdef SEQDET_MASK_EN
  logic [PAT_W-1:0] mask_in = '1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_p #(.PAT_W(PAT_W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .pat_load(pat_load),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in),
`ifdef SEQDET_MASK_EN
    .mask_in(mask_in),
`endif
    .cnt_clr(cnt_clr), .flag(flag), .match_cnt(match_cnt), .busy_fill(busy_fill)
  );

  seq_detect_p #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .pat_load(pat_load),
    .pat_in(pat_in), .len_in(len_in), .ovl_in(ovl_in),
`ifdef SEQDET_MASK_EN
    .mask_in(mask_in),
`endif
    .cnt_clr(cnt_clr), .flag(flag2), .match_cnt(match_cnt2), .busy_fill(busy_fill2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One valid beat; flag checked during the following cycle.
  task automatic send(input logic d, input logic exp_flag, input string tag);
    @(negedge clk);
    din     = d;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    chk(tag, 32'(flag), 32'(exp_flag));
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input logic [31:0] exp_flags,
                           input string tag);
    logic [31:0] b, e;
    b = bits;
    e = exp_flags;
    for (int i = n - 1; i >= 0; i--) begin
      send(b[i], e[i], $sformatf("%s_bit%0d", tag, n - i));
    end
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk(tag, 32'(flag), 32'd0);
    end
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [LW-1:0] l, input logic o);
    @(negedge clk);
    pat_load = 1'b1;
    pat_in   = p;
    len_in   = l;
    ovl_in   = o;
    din_vld  = 1'b0;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    chk("load_flag", 32'(flag), 32'd0);
  endtask

  initial begin
    rst = 1'b0; din = 1'b0; din_vld = 1'b0; pat_load = 1'b0;
    pat_in = '0; len_in = '0; ovl_in = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_busy", 32'(busy_fill), 32'd1);

    // Reset pattern 01010101, len 8, overlapping.
    send_bits(32'b0101010101, 10, 32'b0000000101, "ovl");
    chk("ovl_cnt", 32'(match_cnt), 32'd2);
    chk("ovl_cnt2", 32'(match_cnt2), 32'd2);
    chk("ovl_busy", 32'(busy_fill), 32'd0);

    // Same pattern, non-overlapping.
    load(8'h55, LW'(8), OVL_OFF);
    send_bits(32'b01010101, 8, 32'b00000001, "novl_a");
    chk("novl_busy", 32'(busy_fill), 32'd1);
    send_bits(32'b01010101, 8, 32'b00000001, "novl_b");
    chk("novl_cnt", 32'(match_cnt), 32'd4);
    chk("sat_cnt2", 32'(match_cnt2), 32'd3);

    // Short pattern 110 with idle gaps between valid beats.
    load(8'b0000_0110, LW'(3), OVL_ON);
    send(1'b1, 1'b0, "gap_b1");
    idle(2, "gap_idle1");
    send(1'b1, 1'b0, "gap_b2");
    idle(2, "gap_idle2");
    send(1'b0, 1'b1, "gap_b3");
    idle(1, "gap_after");
    chk("gap_cnt", 32'(match_cnt), 32'd5);
    chk("gap_cnt2", 32'(match_cnt2), 32'd3);

    // Load on the cycle of the completing bit suppresses the match.
    send(1'b1, 1'b0, "coll_b1");
    send(1'b1, 1'b0, "coll_b2");
    @(negedge clk);
    din = 1'b0; din_vld = 1'b1; pat_load = 1'b1;
    pat_in = 8'b0000_0110; len_in = LW'(3); ovl_in = OVL_ON;
    @(posedge clk);
    #1;
    din_vld = 1'b0; pat_load = 1'b0;
    chk("coll_flag", 32'(flag), 32'd0);
    chk("coll_cnt", 32'(match_cnt), 32'd5);
    send_bits(32'b110, 3, 32'b001, "post_coll");
    chk("post_coll_cnt", 32'(match_cnt), 32'd6);

    // Length 0 disables detection.
    load(8'h00, LW'(0), OVL_ON);
    chk("len0_busy", 32'(busy_fill), 32'd0);
    for (int i = 0; i < 32; i++) begin
      send(1'($urandom_range(0, 1)), 1'b0, $sformatf("len0_bit%0d", i));
    end
    chk("len0_cnt", 32'(match_cnt), 32'd6);

    // Oversized length clamps to PAT_W.
    load(8'h55, LW'(15), OVL_ON);
    send_bits(32'b01010101, 8, 32'b00000001, "clamp");
    chk("clamp_cnt", 32'(match_cnt), 32'd7);

    // Clear coincident with a match: count 0, flag still pulses.
    load(8'b0000_0110, LW'(3), OVL_ON);
    send(1'b1, 1'b0, "clr_b1");
    send(1'b1, 1'b0, "clr_b2");
    @(negedge clk);
    din = 1'b0; din_vld = 1'b1; cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0; cnt_clr = 1'b0;
    chk("clr_flag", 32'(flag), 32'd1);
    chk("clr_cnt", 32'(match_cnt), 32'd0);
    chk("clr_cnt2", 32'(match_cnt2), 32'd0);

    // Reset mid-sequence discards the partial match.
    load(8'h55, LW'(8), OVL_OFF);
    send_bits(32'b01010101, 8, 32'b00000001, "pre_rst");
    send_bits(32'b0101010, 7, 32'b0000000, "part");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_flag", 32'(flag), 32'd0);
    chk("mid_rst_cnt", 32'(match_cnt), 32'd0);
    chk("mid_rst_cnt2", 32'(match_cnt2), 32'd0);
    chk("mid_rst_busy", 32'(busy_fill), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(1'b1, 1'b0, "rel_bit8");
    send_bits(32'b01010101, 8, 32'b00000001, "rel");
    chk("rel_cnt", 32'(match_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_p.md
# seq_detect_p

Parametrised, runtime-programmable serial bit-sequence detector, the successor of the team's fixed-pattern Mealy detectors. It samples one bit per qualified cycle and compares the most recent `pat_len` bits against a loaded pattern. On a match it pulses `flag` and increments a saturating match counter. It sits on serial receive paths, both as a frame/sync-word spotter and as a drop-in replacement for the hard-coded 8-bit detector.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: match counter width.
- `RST_PAT`, 8'b0101_0101: pattern in force after reset (PAT_W bits).
- `RST_LEN`, PAT_W: pattern length after reset.
- `RST_OVL`, 1: overlap mode after reset.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  asynchronous reset, active-low.
- `din`  in  1  serial data bit.
- `din_vld`  in  1  `din` qualifier; only cycles with `din_vld`=1 advance the detector.
- `pat_load`  in  1  one-cycle strobe; captures `pat_in`, `len_in`, `ovl_in`.
- `pat_in`  in  PAT_W  new pattern, right-aligned; bit `len_in-1` is the first bit expected on the line.
- `len_in`  in  $clog2(PAT_W+1)  new length.
- `ovl_in`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `flag`  out  1  registered one-cycle match pulse.
- `match_cnt`  out  CNT_W  saturating count of matches.
- `busy_fill`  out  1  high while fewer than `pat_len` bits have been received since the last reset, load or non-overlap match.

## Operation
- Registers: `hist` (PAT_W shift, new bit enters at LSB), `fill` (0..PAT_W, saturating), `pat`, `pat_len`, `ovl`, `flag`, `match_cnt`.
- Per `din_vld` beat: `hist_n = {hist[PAT_W-2:0], din}`; `fill_n = min(fill+1, PAT_W)`.
- Match condition: `pat_len ≠ 0`, `fill_n ≥ pat_len`, and the low `pat_len` bits of `hist_n` equal the low `pat_len` bits of `pat`.
- On a match:
  - `flag` ← 1 in the next cycle.
  - `match_cnt` increments and saturates at 2^CNT_W−1.
  - If `ovl`=0, `fill` ← 0, so a new match needs `pat_len` fresh bits.
  - If `ovl`=1, `fill` is kept.
- `flag` is 0 on every cycle not following a matching beat. Cycles with `din_vld`=0 hold all state and leave `flag` at 0.
- `pat_load`:
  - Captures the pattern, `ovl`, and `pat_len = min(len_in, PAT_W)`.
  - Clears `hist` and `fill`; `match_cnt` is kept.
  - `len_in`=0 disables detection; `flag` never asserts.
- Priority:
  - `pat_load` over `din_vld`: the same-cycle bit is discarded and no match is evaluated.
  - `cnt_clr` over increment: the count becomes 0, and `flag` still pulses if that beat matched.
- Reset (async assert, sync release): `flag`=0, `match_cnt`=0, `hist`=0, `fill`=0, `pat`=RST_PAT, `pat_len`=RST_LEN, `ovl`=RST_OVL. Assertion mid-sequence discards the partial match immediately.

## Timing
- Latency: the matching bit is sampled at edge N, and `flag` is high during cycle N+1 (one cycle).
- Throughput: one bit per clock; back-to-back overlap matches give `flag` high on consecutive cycles.
- `match_cnt` updates on the same edge that sets `flag`.
- `busy_fill` is combinational from `fill` and `pat_len`.
- The first bit after `pat_load` or reset release can be sampled on the next edge.

## Configuration
- `SEQDET_MASK_EN` defined:
  - Adds input `mask_in` [PAT_W], captured on `pat_load`. Reset value is all ones.
  - Compare bits where `mask`=0 are don't-care.
- Without the macro there is no port and all `pat_len` bits are compared.

## Structure
- Package `seq_detect_pkg`:
  - Length-width function `LEN_W(PAT_W)`.
  - Overlap mode constants `OVL_ON`/`OVL_OFF`.
  - Default pattern constant `SEQ_0101`.
- Sub-module `seq_detect_cmp`: combinational length-limited (optionally masked) equality of `hist_n` against `pat`. It is kept separate so verification can exhaustively check it.
- The top level holds all registers, priority logic and the counter.

## Test plan
- Reset defaults (01010101, len 8, overlap); feed 0101010101 → `flag` after bits 8 and 10, `match_cnt`=2.
- Load same pattern with `ovl_in`=0; feed 16 bits 0101… → `flag` after bits 8 and 16 only, count +2.
- Load `pat_in`=3'b110, `len_in`=3; feed 1,1,0 with `din_vld` gaps of 2 idle cycles → single `flag` one cycle after the third valid beat.
- `pat_load` on the cycle of a completing bit → no `flag`; `len_in`=0 → no `flag` for 32 random bits.
- CNT_W=2: 5 matches → `match_cnt` holds 3; `cnt_clr` coincident with a match → count 0, `flag` 1.
- Assert `rst` low after 7 of 8 pattern bits → outputs zero immediately; after release, the 8th bit alone → no `flag`.
